// File: rtl/gps_ca_code_gen_pkg.sv
// Shared constants for the GPS L1 C/A code generator.
//   - LFSR width, code length and G1/G2 feedback tap masks
//   - PRN -> (s1,s2) G2 phase-select tap table (ICD-GPS-200, PRN 1..32)
//   - chip combining helper
// Tap masks: bit (k-1) set means stage k feeds the XOR feedback.
package gps_ca_code_gen_pkg;

  localparam int LFSR_W     = 10;
  localparam int CHIP_COUNT = 1023;

  // G1 = 1 + x^3 + x^10 -> stages 3,10
  localparam logic [LFSR_W-1:0] G1_TAPS = 10'h204;
  // G2 = 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10 -> stages 2,3,6,8,9,10
  localparam logic [LFSR_W-1:0] G2_TAPS = 10'h3A6;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } tap_pair_t;

  function automatic tap_pair_t prn_taps(input logic [5:0] prn);
    tap_pair_t t;
    case (prn)
      6'd1:    t = {4'd2, 4'd6};
      6'd2:    t = {4'd3, 4'd7};
      6'd3:    t = {4'd4, 4'd8};
      6'd4:    t = {4'd5, 4'd9};
      6'd5:    t = {4'd1, 4'd9};
      6'd6:    t = {4'd2, 4'd10};
      6'd7:    t = {4'd1, 4'd8};
      6'd8:    t = {4'd2, 4'd9};
      6'd9:    t = {4'd3, 4'd10};
      6'd10:   t = {4'd2, 4'd3};
      6'd11:   t = {4'd3, 4'd4};
      6'd12:   t = {4'd5, 4'd6};
      6'd13:   t = {4'd6, 4'd7};
      6'd14:   t = {4'd7, 4'd8};
      6'd15:   t = {4'd8, 4'd9};
      6'd16:   t = {4'd9, 4'd10};
      6'd17:   t = {4'd1, 4'd4};
      6'd18:   t = {4'd2, 4'd5};
      6'd19:   t = {4'd3, 4'd6};
      6'd20:   t = {4'd4, 4'd7};
      6'd21:   t = {4'd5, 4'd8};
      6'd22:   t = {4'd6, 4'd9};
      6'd23:   t = {4'd1, 4'd3};
      6'd24:   t = {4'd4, 4'd6};
      6'd25:   t = {4'd5, 4'd7};
      6'd26:   t = {4'd6, 4'd8};
      6'd27:   t = {4'd7, 4'd9};
      6'd28:   t = {4'd8, 4'd10};
      6'd29:   t = {4'd1, 4'd6};
      6'd30:   t = {4'd2, 4'd7};
      6'd31:   t = {4'd3, 4'd8};
      6'd32:   t = {4'd4, 4'd9};
      default: t = {4'd2, 4'd6};
    endcase
    return t;
  endfunction

  // chip = G1 stage 10 ^ G2 stage s1 ^ G2 stage s2 (stage k lives in bit k-1)
  function automatic logic ca_chip(input logic [LFSR_W-1:0] g1,
                                   input logic [LFSR_W-1:0] g2,
                                   input tap_pair_t         t);
    return g1[LFSR_W-1] ^ g2[t.s1 - 4'd1] ^ g2[t.s2 - 4'd1];
  endfunction

endpackage

// File: rtl/gps_ca_lfsr10.sv
// Generic 10-bit Fibonacci LFSR.
//   clkin     : clock
//   rst       : async active-low reset, loads all ones
//   shift     : advance one step (stage1 <= feedback, stage k+1 <= stage k)
//   load_ones : synchronous preset to all ones, wins over shift
//   state     : register contents, bit k-1 = stage k
module gps_ca_lfsr10
  import gps_ca_code_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS = G1_TAPS
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              shift,
  input  logic              load_ones,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state <= '1;
    end else if (load_ones) begin
      state <= '1;
    end else if (shift) begin
      state <= {state[LFSR_W-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/gps_ca_code_gen.sv
// GPS L1 C/A code generator.
//   clkin    : system clock          rst      : async active-low reset
//   code_clk : chip clock (clkin domain), rising edge = chip advance
//   enable   : run / hold at code start
//   prn_sel  : requested PRN         prn_load : one-cycle load request
//   ca_code  : current chip          chip_stb : new-chip pulse
//   chip_idx : current chip index    epoch    : chip-0 pulse
//   ms_cnt   : epoch count in bit    bit_edge : data-bit boundary pulse
//   prn_err  : sticky, last load was an invalid PRN
module gps_ca_code_gen
  import gps_ca_code_gen_pkg::*;
#(
  parameter int NUM_PRN    = 32,
  parameter int MS_PER_BIT = 20
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       code_clk,
  input  logic       enable,
  input  logic [5:0] prn_sel,
  input  logic       prn_load,
  output logic       ca_code,
  output logic       chip_stb,
  output logic [9:0] chip_idx,
  output logic       epoch,
  output logic [4:0] ms_cnt,
  output logic       bit_edge,
  output logic       prn_err
);

  localparam logic [9:0] CHIP_LAST = 10'(CHIP_COUNT - 1);
  localparam logic [4:0] MS_LAST   = 5'(MS_PER_BIT - 1);

  logic              code_clk_q;
  logic [9:0]        next_idx;     // index of the chip the next advance presents
  logic [5:0]        active_prn;
  logic [5:0]        pend_prn;
  logic              fresh;        // no epoch presented since enable/reset
  logic [LFSR_W-1:0] g1;
  logic [LFSR_W-1:0] g2;

  logic      adv;
  logic      step;
  logic      at_start;
  logic      at_wrap;
  logic      prn_ok;
  logic [5:0] eff_prn;
  tap_pair_t taps;

  assign adv      = code_clk & ~code_clk_q;
  assign step     = adv & enable;
  assign at_start = (next_idx == 10'd0);
  assign at_wrap  = (next_idx == CHIP_LAST);
  assign prn_ok   = (prn_sel != 6'd0) && (int'(prn_sel) <= NUM_PRN);
  // Chip 0 is generated with the pending PRN so a switch lands exactly on the epoch;
  // the pending register still holds the pre-load value on a coincident load.
  assign eff_prn  = at_start ? pend_prn : active_prn;
  assign taps     = prn_taps(eff_prn);

  gps_ca_lfsr10 #(.TAPS(G1_TAPS)) u_g1 (
    .clkin     (clkin),
    .rst       (rst),
    .shift     (step),
    .load_ones (~enable | (step & at_wrap)),
    .state     (g1)
  );

  gps_ca_lfsr10 #(.TAPS(G2_TAPS)) u_g2 (
    .clkin     (clkin),
    .rst       (rst),
    .shift     (step),
    .load_ones (~enable | (step & at_wrap)),
    .state     (g2)
  );

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      code_clk_q <= 1'b0;
      ca_code    <= 1'b0;
      chip_stb   <= 1'b0;
      epoch      <= 1'b0;
      bit_edge   <= 1'b0;
      chip_idx   <= 10'd0;
      next_idx   <= 10'd0;
      ms_cnt     <= 5'd0;
      prn_err    <= 1'b0;
      active_prn <= 6'd1;
      pend_prn   <= 6'd1;
      fresh      <= 1'b1;
    end else begin
      code_clk_q <= code_clk;
      chip_stb   <= 1'b0;
      epoch      <= 1'b0;
      bit_edge   <= 1'b0;

      if (prn_load) begin
        if (prn_ok) begin
          pend_prn <= prn_sel;
          prn_err  <= 1'b0;
        end else begin
          prn_err  <= 1'b1;
        end
      end

      if (!enable) begin
        next_idx   <= 10'd0;
        chip_idx   <= 10'd0;
        ms_cnt     <= 5'd0;
        fresh      <= 1'b1;
        active_prn <= pend_prn;
      end else if (adv) begin
        ca_code  <= ca_chip(g1, g2, taps);
        chip_idx <= next_idx;
        chip_stb <= 1'b1;
        next_idx <= at_wrap ? 10'd0 : next_idx + 10'd1;
        if (at_start) begin
          epoch      <= 1'b1;
          active_prn <= pend_prn;
          fresh      <= 1'b0;
          if (fresh || ms_cnt == MS_LAST) begin
            ms_cnt   <= 5'd0;
            bit_edge <= 1'b1;
          end else begin
            ms_cnt   <= ms_cnt + 5'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gps_ca_code_gen.sv
// Scoreboard bench for gps_ca_code_gen. Reference codes come from the G1/G2
// output-sequence recurrences with G2 phase delays, not from register stepping.
module tb_gps_ca_code_gen;

  localparam int MS    = 20;
  localparam int NCHIP = 1023;

  logic       clkin = 1'b0;
  logic       rst = 1'b0;
  logic       code_clk = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] prn_sel = 6'd1;
  logic       prn_load = 1'b0;
  logic       ca_code, chip_stb, epoch, bit_edge, prn_err;
  logic [9:0] chip_idx;
  logic [4:0] ms_cnt;

  gps_ca_code_gen #(.NUM_PRN(32), .MS_PER_BIT(MS)) dut (
    .clkin    (clkin),
    .rst      (rst),
    .code_clk (code_clk),
    .enable   (enable),
    .prn_sel  (prn_sel),
    .prn_load (prn_load),
    .ca_code  (ca_code),
    .chip_stb (chip_stb),
    .chip_idx (chip_idx),
    .epoch    (epoch),
    .ms_cnt   (ms_cnt),
    .bit_edge (bit_edge),
    .prn_err  (prn_err)
  );

  always #5 clkin = ~clkin;

  int s1_tab [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int s2_tab [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
  bit codes [1:32][0:NCHIP-1];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_idx = 0, m_ms = 0, m_active = 1, m_pend = 1;
  bit m_fresh = 1, m_err = 0, m_prev = 0;
  int exp_q [$];

  // monitor observations
  logic [9:0] cap = '0;
  int ep_cnt = 0, be_cnt = 0;

  bit rst_w = 0, en_w = 0, rnd_loads = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic build_codes();
    bit o1 [0:NCHIP+15];
    bit o2 [0:NCHIP+15];
    for (int n = 0; n < 10; n++) begin
      o1[n] = 1'b1;
      o2[n] = 1'b1;
    end
    for (int n = 10; n < NCHIP + 16; n++) begin
      o1[n] = o1[n-3] ^ o1[n-10];
      o2[n] = o2[n-2] ^ o2[n-3] ^ o2[n-6] ^ o2[n-8] ^ o2[n-9] ^ o2[n-10];
    end
    // G2 stage s at step n equals the G2 output sequence delayed by (10 - s)
    for (int p = 1; p <= 32; p++)
      for (int n = 0; n < NCHIP; n++)
        codes[p][n] = o1[n] ^ o2[n + 10 - s1_tab[p]] ^ o2[n + 10 - s2_tab[p]];
  endtask

  function automatic logic [9:0] prefix_of(input int p);
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[9-i] = codes[p][i];
    return v;
  endfunction

  // one clkin cycle of stimulus, model updated with what the DUT will see
  task automatic tick(input bit rst_v, input bit en_v, input bit cc_v,
                      input bit ld_v, input logic [5:0] sel_v);
    bit adv, ep, be;
    int e;
    @(negedge clkin);
    rst = rst_v; enable = en_v; code_clk = cc_v; prn_load = ld_v; prn_sel = sel_v;
    if (!rst_v) begin
      m_idx = 0; m_ms = 0; m_active = 1; m_pend = 1;
      m_fresh = 1; m_err = 0; m_prev = 0;
    end else begin
      adv = cc_v & ~m_prev;
      m_prev = cc_v;
      if (!en_v) begin
        m_idx = 0;
        m_fresh = 1;
      end else if (adv) begin
        ep = (m_idx == 0);
        be = 0;
        if (ep) begin
          m_active = m_pend;
          if (m_fresh) begin
            m_ms = 0; be = 1; m_fresh = 0;
          end else begin
            m_ms = (m_ms + 1) % MS;
            be = (m_ms == 0);
          end
        end
        e = (int'(codes[m_active][m_idx]) << 17) | (m_idx << 7) | (int'(ep) << 6)
            | (m_ms << 1) | int'(be);
        exp_q.push_back(e);
        m_idx = (m_idx + 1) % NCHIP;
      end
      if (ld_v) begin
        if (sel_v >= 1 && sel_v <= 32) begin
          m_pend = sel_v; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit cc, ld;
      logic [5:0] sel;
      cc = ($urandom_range(15) == 0) ? code_clk : ~code_clk;
      ld = 0;
      sel = prn_sel;
      if (rnd_loads && $urandom_range(1999) == 0) begin
        ld = 1;
        sel = 6'($urandom_range(40));
      end
      tick(rst_w, en_w, cc, ld, sel);
    end
  endtask

  task automatic load(input logic [5:0] sel);
    tick(rst_w, en_w, ~code_clk, 1'b1, sel);
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (m_idx != target && n < 5000) begin
      run(1);
      n++;
    end
    if (m_idx != target) chk("wait_idx_timeout", m_idx, target);
  endtask

  task automatic check_prefix(input string nm, input logic [9:0] want);
    wait_idx(15);
    run(4);
    chk(nm, int'(cap), int'(want));
  endtask

  // monitor: pops one expectation per chip_stb
  initial begin
    int e;
    forever begin
      @(posedge clkin);
      #1;
      chk("prn_err", int'(prn_err), int'(m_err));
      if (chip_stb) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_chip_stb", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("chip{ca,idx,epoch,ms,bit_edge}",
              int'({ca_code, chip_idx, epoch, ms_cnt, bit_edge}), e);
        end
        if (chip_idx < 10) cap[9 - chip_idx] = ca_code;
        if (epoch) ep_cnt++;
        if (bit_edge) be_cnt++;
      end else begin
        chk("pulses_without_stb", int'({epoch, bit_edge}), 0);
      end
    end
  end

  initial begin
    int n;
    build_codes();

    rst_w = 0; en_w = 0;
    run(3);
    chk("rst_ca_code", int'(ca_code), 0);
    chk("rst_chip_idx", int'(chip_idx), 0);
    chk("rst_ms_cnt", int'(ms_cnt), 0);
    chk("rst_pulses", int'({chip_stb, epoch, bit_edge}), 0);
    chk("rst_prn_err", int'(prn_err), 0);

    rst_w = 1;
    run(2);
    en_w = 1;
    cap = '0;
    check_prefix("prn1_prefix", 10'b1100100000);

    // PRN switch requested mid-epoch
    wait_idx(500);
    load(6'd5);
    wait_idx(0);
    cap = '0;
    check_prefix("prn5_prefix", prefix_of(5));

    // invalid requests then a valid one
    load(6'd0);
    run(3);
    chk("err_after_0", int'(prn_err), 1);
    load(6'd40);
    run(3);
    chk("err_after_40", int'(prn_err), 1);
    load(6'd3);
    run(3);
    chk("err_cleared", int'(prn_err), 0);
    load(6'd2);                       // overwrites pending 3
    wait_idx(0);
    cap = '0;
    check_prefix("prn2_prefix", 10'b1110010000);
    wait_idx(0);
    cap = '0;
    check_prefix("prn2_repeat", 10'b1110010000);

    // load coincident with the chip-0 advance keeps the old PRN for that epoch
    wait_idx(0);
    if (code_clk) tick(rst_w, en_w, 1'b0, 1'b0, prn_sel);
    cap = '0;
    tick(rst_w, en_w, 1'b1, 1'b1, 6'd6);
    check_prefix("coincident_load_old_prn", 10'b1110010000);
    wait_idx(0);
    cap = '0;
    check_prefix("coincident_load_next_prn", prefix_of(6));

    // reset mid-epoch
    wait_idx(700);
    rst_w = 0;
    run(2);
    chk("midrst_chip_idx", int'(chip_idx), 0);
    rst_w = 1;
    cap = '0;
    check_prefix("prefix_after_rst", 10'b1100100000);

    // enable dropped for about 5 chips
    wait_idx(300);
    en_w = 0;
    run(10);
    chk("dis_chip_idx", int'(chip_idx), 0);
    chk("dis_ms_cnt", int'(ms_cnt), 0);
    en_w = 1;
    cap = '0;
    check_prefix("prefix_after_enable", 10'b1100100000);

    // 21 epochs from a fresh enable with random PRN traffic
    en_w = 0;
    run(3);
    ep_cnt = 0;
    be_cnt = 0;
    en_w = 1;
    rnd_loads = 1;
    n = 0;
    while (ep_cnt < 21 && n < 60000) begin
      run(1);
      n++;
    end
    rnd_loads = 0;
    chk("epochs_seen", ep_cnt, 21);
    chk("bit_edges_in_21_epochs", be_cnt, 2);

    run(10);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
